// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and the
// instruction memory. The fetch stage is the master. It drives the request and
// the address. The memory is the slave. It returns the word and the valid strobe.
interface fetch_stage_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata;
   logic        imemValid;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemRdata,
      input  imemValid
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemRdata,
      output imemValid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// The stage holds the PC and fetches words over a request/valid handshake.
// It writes the fetched word and fetchAddr+4 into IF/ID.
// A one-entry skid buffer catches a word that returns while decode is stalled.
// The DRAIN state keeps the old address on the bus until an abandoned request
// has returned, so that a stale word is never taken for the redirect target.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic                 i_clk,
   input  logic                 i_resetN,
   fetch_stage_if.master        imem,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_redirect,
   input  logic [31:0]          i_redirectPc,
   output logic [31:0]          o_pc,
   output logic                 o_ifIdValid,
   output logic [31:0]          o_ifIdInstr,
   output logic [31:0]          o_ifIdPcPlus4,
   output logic [15:0]          o_ifIdImm16
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_imemReq;
   logic [31:0] r_pc;
   logic [31:0] r_drainAddr;
   logic [31:0] r_skidInstr;
   logic [31:0] r_skidPcPlus4;
   logic        r_ifIdValid;
   logic [31:0] r_ifIdInstr;
   logic [31:0] r_ifIdPcPlus4;

   logic [31:0] w_redirectTarget;
   logic [31:0] w_pcPlus4;

   // The redirect target is forced onto a word boundary. PC+4 wraps modulo 2^32.
   assign w_redirectTarget = {i_redirectPc[31:2], 2'b00};
   assign w_pcPlus4        = r_pc + 32'd4;

   // While draining, the abandoned address stays on the bus. Otherwise the bus shows the PC.
   assign imem.imemReq  = r_imemReq;
   assign imem.imemAddr = (r_state == DRAIN) ? r_drainAddr : r_pc;

   assign o_pc          = r_pc;
   assign o_ifIdValid   = r_ifIdValid;
   assign o_ifIdInstr   = r_ifIdInstr;
   assign o_ifIdPcPlus4 = r_ifIdPcPlus4;
   assign o_ifIdImm16   = r_ifIdInstr[15:0];

   // Fetch FSM, PC, skid buffer and IF/ID register.
   // Flush has the highest priority on IF/ID, then stall, then a load.
   // A load is therefore only taken when neither flush nor stall blocks it.
   always_ff @(posedge i_clk) begin
      if (!i_resetN) begin
         r_state       <= IDLE;
         r_imemReq     <= 1'b0;
         r_pc          <= RESET_PC;
         r_drainAddr   <= 32'h0000_0000;
         r_skidInstr   <= NOP_INSTR;
         r_skidPcPlus4 <= 32'h0000_0000;
         r_ifIdValid   <= 1'b0;
         r_ifIdInstr   <= NOP_INSTR;
         r_ifIdPcPlus4 <= 32'h0000_0000;
      end else begin
         if (i_flush) begin
            r_ifIdValid <= 1'b0;
            r_ifIdInstr <= NOP_INSTR;
         end
         case (r_state)
            IDLE: begin
               r_state   <= WAIT;
               r_imemReq <= 1'b1;
            end
            WAIT: begin
               if (i_redirect) begin
                  r_pc <= w_redirectTarget;
                  if (!imem.imemValid) begin
                     r_drainAddr <= r_pc;
                     r_state     <= DRAIN;
                  end
               end else if (imem.imemValid) begin
                  r_pc <= w_pcPlus4;
                  if (!i_flush) begin
                     if (i_stall) begin
                        r_skidInstr   <= imem.imemRdata;
                        r_skidPcPlus4 <= w_pcPlus4;
                        r_state       <= FULL;
                        r_imemReq     <= 1'b0;
                     end else begin
                        r_ifIdValid   <= 1'b1;
                        r_ifIdInstr   <= imem.imemRdata;
                        r_ifIdPcPlus4 <= w_pcPlus4;
                     end
                  end
               end
            end
            FULL: begin
               if (i_redirect) begin
                  r_pc      <= w_redirectTarget;
                  r_state   <= WAIT;
                  r_imemReq <= 1'b1;
               end else if (!i_stall) begin
                  if (!i_flush) begin
                     r_ifIdValid   <= 1'b1;
                     r_ifIdInstr   <= r_skidInstr;
                     r_ifIdPcPlus4 <= r_skidPcPlus4;
                  end
                  r_state   <= WAIT;
                  r_imemReq <= 1'b1;
               end
            end
            DRAIN: begin
               if (i_redirect) begin
                  r_pc <= w_redirectTarget;
               end
               if (imem.imemValid) begin
                  r_state <= WAIT;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_imemReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. It has three parts.
// First, a table of directed vectors covers streaming, stall, redirect with
// flush, the drain after a late response, and reset.
// Second, a second instance with RESET_PC = FFFF_FFFC checks PC wrap-around.
// Third, a randomized phase is checked against a behavioural model. The model
// holds the PC, a queue for the buffered word and a flag for the stale request.
module tb_fetch_stage;

   localparam logic [31:0] TB_NOP = 32'h0000_0013;

   typedef struct {
      logic        resetN;
      logic        stall;
      logic        flush;
      logic        redirect;
      logic [31:0] redirectPc;
      logic        valid;
      logic        expReq;
      logic [31:0] expAddr;
      logic [31:0] expPc;
      logic        expValid;
      logic [31:0] expPcPlus4;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcPlus4;
   } entry_t;

   int total = 0;
   int bad   = 0;

   logic        clk = 1'b0;
   logic        resetN, stall, flush, redirect, memValid;
   logic [31:0] redirectPc;
   logic        resetN2;

   logic [31:0] pc, ifIdInstr, ifIdPcPlus4;
   logic        ifIdValid;
   logic [15:0] ifIdImm16;
   logic [31:0] pc2, ifIdInstr2, ifIdPcPlus42;
   logic        ifIdValid2;
   logic [15:0] ifIdImm162;

   // Behavioural model state
   logic        mStarted;
   logic [31:0] mPc;
   logic        mStale;
   logic [31:0] mStaleAddr;
   entry_t      mBuf[$];
   logic        mIfValid;
   logic [31:0] mIfInstr;
   logic [31:0] mIfPcPlus4;

   vec_t vecs[30];

   function automatic logic [31:0] pattern(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
   endfunction

   always #5 clk = ~clk;

   fetch_stage_if memIf();
   fetch_stage_if wrapIf();

   // The memory answers combinationally, with a word derived from the address on the bus.
   assign memIf.imemValid  = memValid;
   assign memIf.imemRdata  = pattern(memIf.imemAddr);
   assign wrapIf.imemValid = 1'b1;
   assign wrapIf.imemRdata = pattern(wrapIf.imemAddr);

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(TB_NOP)) dut (
      .i_clk(clk), .i_resetN(resetN), .imem(memIf.master),
      .i_stall(stall), .i_flush(flush), .i_redirect(redirect), .i_redirectPc(redirectPc),
      .o_pc(pc), .o_ifIdValid(ifIdValid), .o_ifIdInstr(ifIdInstr),
      .o_ifIdPcPlus4(ifIdPcPlus4), .o_ifIdImm16(ifIdImm16)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dutWrap (
      .i_clk(clk), .i_resetN(resetN2), .imem(wrapIf.master),
      .i_stall(1'b0), .i_flush(1'b0), .i_redirect(1'b0), .i_redirectPc(32'h0000_0000),
      .o_pc(pc2), .o_ifIdValid(ifIdValid2), .o_ifIdInstr(ifIdInstr2),
      .o_ifIdPcPlus4(ifIdPcPlus42), .o_ifIdImm16(ifIdImm162)
   );

   function automatic vec_t mkVec(input logic r, input logic s, input logic f, input logic rd,
                                  input logic [31:0] rpc, input logic v, input logic eReq,
                                  input logic [31:0] eAddr, input logic [31:0] ePc,
                                  input logic eV, input logic [31:0] eP4);
      vec_t t;
      t.resetN = r; t.stall = s; t.flush = f; t.redirect = rd; t.redirectPc = rpc;
      t.valid = v; t.expReq = eReq; t.expAddr = eAddr; t.expPc = ePc;
      t.expValid = eV; t.expPcPlus4 = eP4;
      return t;
   endfunction

   task automatic applyStimulus(input vec_t t);
      resetN     = t.resetN;
      stall      = t.stall;
      flush      = t.flush;
      redirect   = t.redirect;
      redirectPc = t.redirectPc;
      memValid   = t.valid;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Advance the model by one clock edge, using the inputs currently applied.
   task automatic modelStep();
      logic [31:0] target;
      logic [31:0] oldPc;
      entry_t      e;
      target = {redirectPc[31:2], 2'b00};
      oldPc  = mPc;
      if (!resetN) begin
         mStarted = 1'b0; mPc = 32'h0; mStale = 1'b0; mStaleAddr = 32'h0;
         mBuf.delete(); mIfValid = 1'b0; mIfInstr = TB_NOP; mIfPcPlus4 = 32'h0;
      end else begin
         if (flush) begin
            mIfValid = 1'b0;
            mIfInstr = TB_NOP;
         end
         if (!mStarted) begin
            mStarted = 1'b1;
         end else if (mStale) begin
            if (redirect) mPc = target;
            if (memValid) mStale = 1'b0;
         end else if (mBuf.size() != 0) begin
            if (redirect) begin
               mBuf.delete();
               mPc = target;
            end else if (!stall) begin
               e = mBuf.pop_front();
               if (!flush) begin
                  mIfValid = 1'b1; mIfInstr = e.instr; mIfPcPlus4 = e.pcPlus4;
               end
            end
         end else begin
            if (redirect) begin
               mPc = target;
               if (!memValid) begin
                  mStale = 1'b1;
                  mStaleAddr = oldPc;
               end
            end else if (memValid) begin
               mPc = oldPc + 32'd4;
               if (!flush) begin
                  if (stall) begin
                     mBuf.push_back({pattern(oldPc), oldPc + 32'd4});
                  end else begin
                     mIfValid = 1'b1; mIfInstr = pattern(oldPc); mIfPcPlus4 = oldPc + 32'd4;
                  end
               end
            end
         end
      end
   endtask

   initial begin
      logic        eReq;
      logic [31:0] eInstr;

      // Inputs: reset, stall, flush, redirect, redirectPc, valid.
      // Expected: req, addr, pc, ifIdValid, ifIdPcPlus4.
      vecs[0]  = mkVec(0,0,0,0,32'h0,  0, 0,32'h0,  32'h0,  0,32'h0);
      vecs[1]  = mkVec(1,0,0,0,32'h0,  1, 1,32'h0,  32'h0,  0,32'h0);
      vecs[2]  = mkVec(1,0,0,0,32'h0,  1, 1,32'h4,  32'h4,  1,32'h4);
      vecs[3]  = mkVec(1,0,0,0,32'h0,  1, 1,32'h8,  32'h8,  1,32'h8);
      vecs[4]  = mkVec(1,0,0,0,32'h0,  1, 1,32'hC,  32'hC,  1,32'hC);
      vecs[5]  = mkVec(1,0,0,0,32'h0,  1, 1,32'h10, 32'h10, 1,32'h10);
      vecs[6]  = mkVec(1,1,0,0,32'h0,  1, 0,32'h14, 32'h14, 1,32'h10);
      vecs[7]  = mkVec(1,1,0,0,32'h0,  1, 0,32'h14, 32'h14, 1,32'h10);
      vecs[8]  = mkVec(1,1,0,0,32'h0,  1, 0,32'h14, 32'h14, 1,32'h10);
      vecs[9]  = mkVec(1,0,0,0,32'h0,  1, 1,32'h14, 32'h14, 1,32'h14);
      vecs[10] = mkVec(1,0,0,0,32'h0,  1, 1,32'h18, 32'h18, 1,32'h18);
      vecs[11] = mkVec(1,0,1,1,32'h103,1, 1,32'h100,32'h100,0,32'h18);
      vecs[12] = mkVec(1,0,0,0,32'h0,  1, 1,32'h104,32'h104,1,32'h104);
      vecs[13] = mkVec(1,0,0,0,32'h0,  0, 1,32'h104,32'h104,1,32'h104);
      vecs[14] = mkVec(1,0,0,1,32'h200,0, 1,32'h104,32'h200,1,32'h104);
      vecs[15] = mkVec(1,0,0,0,32'h0,  0, 1,32'h104,32'h200,1,32'h104);
      vecs[16] = mkVec(1,0,0,0,32'h0,  1, 1,32'h200,32'h200,1,32'h104);
      vecs[17] = mkVec(1,0,0,0,32'h0,  1, 1,32'h204,32'h204,1,32'h204);
      vecs[18] = mkVec(1,0,0,1,32'h300,0, 1,32'h204,32'h300,1,32'h204);
      vecs[19] = mkVec(0,0,0,0,32'h0,  1, 0,32'h0,  32'h0,  0,32'h0);
      vecs[20] = mkVec(1,0,0,0,32'h0,  1, 1,32'h0,  32'h0,  0,32'h0);
      vecs[21] = mkVec(1,1,0,0,32'h0,  1, 0,32'h4,  32'h4,  0,32'h0);
      vecs[22] = mkVec(0,0,0,0,32'h0,  1, 0,32'h0,  32'h0,  0,32'h0);
      vecs[23] = mkVec(1,0,0,0,32'h0,  1, 1,32'h0,  32'h0,  0,32'h0);
      vecs[24] = mkVec(1,0,0,0,32'h0,  1, 1,32'h4,  32'h4,  1,32'h4);
      vecs[25] = mkVec(1,1,0,0,32'h0,  1, 0,32'h8,  32'h8,  1,32'h4);
      vecs[26] = mkVec(1,0,0,1,32'h40, 1, 1,32'h40, 32'h40, 1,32'h4);
      vecs[27] = mkVec(1,0,0,0,32'h0,  1, 1,32'h44, 32'h44, 1,32'h44);
      vecs[28] = mkVec(1,0,1,0,32'h0,  1, 1,32'h48, 32'h48, 0,32'h44);
      vecs[29] = mkVec(1,0,0,0,32'h0,  1, 1,32'h4C, 32'h4C, 1,32'h4C);

      resetN2 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("v%0d req", i), 32'(memIf.imemReq), 32'(vecs[i].expReq));
         if (vecs[i].expReq)
            checkOutput($sformatf("v%0d addr", i), memIf.imemAddr, vecs[i].expAddr);
         checkOutput($sformatf("v%0d pc", i), pc, vecs[i].expPc);
         checkOutput($sformatf("v%0d ifIdValid", i), 32'(ifIdValid), 32'(vecs[i].expValid));
         if (vecs[i].expValid || !vecs[i].resetN)
            checkOutput($sformatf("v%0d pcPlus4", i), ifIdPcPlus4, vecs[i].expPcPlus4);
         eInstr = vecs[i].expValid ? pattern(vecs[i].expPcPlus4 - 32'd4) : TB_NOP;
         checkOutput($sformatf("v%0d instr", i), ifIdInstr, eInstr);
         checkOutput($sformatf("v%0d imm16", i), 32'(ifIdImm16), 32'(eInstr[15:0]));
      end

      // PC wrap: the reset PC sits at the last word of the address space.
      checkOutput("wrap reset pc", pc2, 32'hFFFF_FFFC);
      checkOutput("wrap reset req", 32'(wrapIf.imemReq), 32'd0);
      resetN2 = 1'b1;
      @(posedge clk); @(negedge clk);
      checkOutput("wrap first req", 32'(wrapIf.imemReq), 32'd1);
      checkOutput("wrap first addr", wrapIf.imemAddr, 32'hFFFF_FFFC);
      @(posedge clk); @(negedge clk);
      checkOutput("wrap ifIdValid", 32'(ifIdValid2), 32'd1);
      checkOutput("wrap pcPlus4", ifIdPcPlus42, 32'h0000_0000);
      checkOutput("wrap instr", ifIdInstr2, pattern(32'hFFFF_FFFC));
      checkOutput("wrap next addr", wrapIf.imemAddr, 32'h0000_0000);
      @(posedge clk); @(negedge clk);
      checkOutput("wrap second pcPlus4", ifIdPcPlus42, 32'h0000_0004);

      // Randomized run against the behavioural model.
      for (int c = 0; c < 3000; c++) begin
         resetN     = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         redirect   = ($urandom_range(0, 9) == 0);
         redirectPc = $urandom;
         memValid   = ($urandom_range(0, 9) < 6);
         modelStep();
         @(posedge clk);
         @(negedge clk);
         eReq = mStarted && (mBuf.size() == 0);
         checkOutput("rnd req", 32'(memIf.imemReq), 32'(eReq));
         if (eReq)
            checkOutput("rnd addr", memIf.imemAddr, mStale ? mStaleAddr : mPc);
         checkOutput("rnd pc", pc, mPc);
         checkOutput("rnd ifIdValid", 32'(ifIdValid), 32'(mIfValid));
         checkOutput("rnd instr", ifIdInstr, mIfInstr);
         checkOutput("rnd imm16", 32'(ifIdImm16), 32'(mIfInstr[15:0]));
         if (mIfValid || !resetN)
            checkOutput("rnd pcPlus4", ifIdPcPlus4, mIfPcPlus4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
